// File: rtl/uart_cmd_responder_if.sv
// Byte handshake bundle between the UART receiver/transmitter pair and the command responder.
// The master side is the UART top level; the slave side is the responder.
interface uart_cmd_responder_if;
   logic       rx_output_data_valid;
   logic [7:0] rx_output_data;
   logic [7:0] tx_input_data;
   logic       tx_input_data_valid;
   logic       tx_output_ready;

   modport master (
      output rx_output_data_valid,
      output rx_output_data,
      output tx_output_ready,
      input  tx_input_data,
      input  tx_input_data_valid
   );

   modport slave (
      input  rx_output_data_valid,
      input  rx_output_data,
      input  tx_output_ready,
      output tx_input_data,
      output tx_input_data_valid
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// Remote end of the UART register protocol: decodes read/write command bytes against a
// 16 x 8-bit register file and answers each command with exactly one response byte.
module uart_cmd_responder #(
   parameter int         TimeoutCycles = 20000,
   parameter logic [7:0] AckByte       = 8'h06,
   parameter logic [7:0] NakByte       = 8'h15
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_cmd_responder_if.slave bus,
   output logic [7:0]          ctrl_out,
   output logic [7:0]          err_count
);
   localparam int TimerWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);
   localparam logic [TimerWidth-1:0] TimerOne  = TimerWidth'(1);
   localparam logic [TimerWidth-1:0] TimerZero = TimerWidth'(0);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_DATA = 2'd1;
   localparam logic [1:0] ST_RESP      = 2'd2;
   localparam logic [2:0] HEADER       = 3'b010;

   logic [1:0]            state_r, state_s;
   logic [TimerWidth-1:0] timer_r, timer_s;
   logic [3:0]            addr_r, addr_s;
   logic [7:0]            resp_r, resp_s;
   logic                  valid_r, valid_s;
   logic [7:0]            err_r, err_s;
   logic                  err_inc_s;
   logic                  wr_en_s;
   logic [7:0]            regs_r [16];

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return 8'hFF;
      end else begin
         return value + 8'h01;
      end
   endfunction

   // Next-state decode for the command protocol.
   always_comb begin
      state_s   = state_r;
      timer_s   = timer_r;
      addr_s    = addr_r;
      resp_s    = resp_r;
      valid_s   = valid_r;
      err_inc_s = 1'b0;
      wr_en_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.rx_output_data_valid) begin
               if (bus.rx_output_data[6:4] != HEADER) begin
                  resp_s    = NakByte;
                  valid_s   = 1'b1;
                  err_inc_s = 1'b1;
                  state_s   = ST_RESP;
               end else if (bus.rx_output_data[7]) begin
                  addr_s  = bus.rx_output_data[3:0];
                  timer_s = TimerZero;
                  state_s = ST_WAIT_DATA;
               end else begin
                  resp_s  = regs_r[bus.rx_output_data[3:0]];
                  valid_s = 1'b1;
                  state_s = ST_RESP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT_DATA: begin
            // A data byte on the timeout cycle still completes the write.
            if (bus.rx_output_data_valid) begin
               wr_en_s = 1'b1;
               resp_s  = AckByte;
               valid_s = 1'b1;
               state_s = ST_RESP;
            end else if (timer_r == TimerLast) begin
               resp_s    = NakByte;
               valid_s   = 1'b1;
               err_inc_s = 1'b1;
               state_s   = ST_RESP;
            end else begin
               timer_s = timer_r + TimerOne;
            end
         end
         ST_RESP: begin
            err_inc_s = bus.rx_output_data_valid;
            if (valid_r && bus.tx_output_ready) begin
               valid_s = 1'b0;
               state_s = ST_IDLE;
            end else begin
               valid_s = 1'b1;
            end
         end
         default: begin
            valid_s = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
      if (err_inc_s) begin
         err_s = sat_inc8(err_r);
      end else begin
         err_s = err_r;
      end
   end

   // Protocol state, response holding register and error counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         timer_r <= TimerZero;
         addr_r  <= 4'h0;
         resp_r  <= 8'h00;
         valid_r <= 1'b0;
         err_r   <= 8'h00;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         addr_r  <= addr_s;
         resp_r  <= resp_s;
         valid_r <= valid_s;
         err_r   <= err_s;
      end
   end

   // Register file; written only when a write's data byte arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_r[i] <= 8'h00;
         end
      end else if (wr_en_s) begin
         regs_r[addr_r] <= bus.rx_output_data;
      end else begin
         regs_r[addr_r] <= regs_r[addr_r];
      end
   end

   assign bus.tx_input_data       = resp_r;
   assign bus.tx_input_data_valid = valid_r;
   assign ctrl_out                = regs_r[0];
   assign err_count               = err_r;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: vector table, protocol corner sequences and a
// randomized phase scored against a transaction-level model of the register protocol.
module tb_uart_cmd_responder;
   localparam int         T   = 20000;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ctrl_out;
   logic [7:0] err_count;

   uart_cmd_responder_if bus ();

   uart_cmd_responder #(.TimeoutCycles(T), .AckByte(ACK), .NakByte(NAK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .ctrl_out  (ctrl_out),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem [16];
   int         err_m;

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] wdata;
      logic       has_data;
      logic [7:0] exp_resp;
      logic [7:0] exp_err;
      logic [7:0] exp_ctrl;
   } vec_t;
   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_output_data_valid = 1'b1;
      bus.rx_output_data       = b;
      tick();
      bus.rx_output_data_valid = 1'b0;
      bus.rx_output_data       = 8'($urandom);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      err_m = 0;
   endtask

   task automatic model_err();
      if (err_m < 255) err_m = err_m + 1;
   endtask

   // Protocol rules at command level: one command (plus data byte) -> one response.
   task automatic model_cmd(input logic [7:0] c, input logic [7:0] d, output logic [7:0] r);
      if (c[6:4] != 3'b010) begin
         model_err();
         r = NAK;
      end else if (c[7]) begin
         mem[c[3:0]] = d;
         r = ACK;
      end else begin
         r = mem[c[3:0]];
      end
   endtask

   task automatic expect_resp(input string name, input logic [7:0] exp);
      check8({name, "_valid"}, {7'd0, bus.tx_input_data_valid}, 8'd1);
      check8({name, "_data"}, bus.tx_input_data, exp);
      check8({name, "_err"}, err_count, 8'(err_m));
      check8({name, "_ctrl"}, ctrl_out, mem[0]);
   endtask

   task automatic accept(input string name);
      bus.tx_output_ready = 1'b1;
      tick();
      check8({name, "_valid_low"}, {7'd0, bus.tx_input_data_valid}, 8'd0);
   endtask

   task automatic do_cmd(input string name, input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      send(c);
      if (c[6:4] == 3'b010 && c[7]) begin
         check8({name, "_wait"}, {7'd0, bus.tx_input_data_valid}, 8'd0);
         send(d);
      end
      model_cmd(c, d, r);
      expect_resp(name, r);
      accept(name);
   endtask

   initial begin
      #2_000_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      logic       bad;
      bus.rx_output_data_valid = 1'b0;
      bus.rx_output_data       = 8'h00;
      bus.tx_output_ready      = 1'b1;
      model_reset();

      // Reset values
      rst_n = 1'b0;
      repeat (5) tick();
      check8("rst_valid", {7'd0, bus.tx_input_data_valid}, 8'd0);
      check8("rst_data", bus.tx_input_data, 8'h00);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (bus.tx_input_data_valid !== 1'b0) bad = 1'b1;
      end
      check8("idle_no_resp", {7'd0, bad}, 8'd0);
      check8("rst_ctrl", ctrl_out, 8'h00);
      check8("rst_err", err_count, 8'h00);

      // Vector table, expectations written out by hand
      vecs[0] = '{8'hA0, 8'h5C, 1'b1, ACK,   8'd0, 8'h5C};
      vecs[1] = '{8'h20, 8'h00, 1'b0, 8'h5C, 8'd0, 8'h5C};
      vecs[2] = '{8'h2F, 8'h00, 1'b0, 8'h00, 8'd0, 8'h5C};
      vecs[3] = '{8'h70, 8'h00, 1'b0, NAK,   8'd1, 8'h5C};
      vecs[4] = '{8'hA3, 8'hA7, 1'b1, ACK,   8'd1, 8'h5C};
      vecs[5] = '{8'h23, 8'h00, 1'b0, 8'hA7, 8'd1, 8'h5C};
      vecs[6] = '{8'hF0, 8'h00, 1'b0, NAK,   8'd2, 8'h5C};
      vecs[7] = '{8'h80, 8'h00, 1'b0, NAK,   8'd3, 8'h5C};
      vecs[8] = '{8'hA0, 8'h11, 1'b1, ACK,   8'd3, 8'h11};
      vecs[9] = '{8'h20, 8'h00, 1'b0, 8'h11, 8'd3, 8'h11};
      for (int i = 0; i < 10; i++) begin
         send(vecs[i].cmd);
         if (vecs[i].has_data) begin
            check8($sformatf("tbl%0d_wait", i), {7'd0, bus.tx_input_data_valid}, 8'd0);
            send(vecs[i].wdata);
         end
         model_cmd(vecs[i].cmd, vecs[i].wdata, r);
         check8($sformatf("tbl%0d_valid", i), {7'd0, bus.tx_input_data_valid}, 8'd1);
         check8($sformatf("tbl%0d_resp", i), bus.tx_input_data, vecs[i].exp_resp);
         check8($sformatf("tbl%0d_err", i), err_count, vecs[i].exp_err);
         check8($sformatf("tbl%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
         accept($sformatf("tbl%0d", i));
      end

      // Write timeout: NAK exactly T cycles after the command cycle
      send(8'hA5);
      bad = 1'b0;
      repeat (T - 1) begin
         tick();
         if (bus.tx_input_data_valid !== 1'b0) bad = 1'b1;
      end
      check8("tmo_early", {7'd0, bad}, 8'd0);
      tick();
      model_err();
      expect_resp("tmo", NAK);
      accept("tmo");
      do_cmd("tmo_follow", 8'h25, 8'h00);

      // Data byte on the timeout cycle wins
      send(8'hA6);
      repeat (T - 1) tick();
      send(8'h3C);
      mem[6] = 8'h3C;
      expect_resp("tmo_edge", ACK);
      accept("tmo_edge");
      do_cmd("tmo_edge_rd", 8'h26, 8'h00);

      // Backpressure with a dropped byte during RESP
      bus.tx_output_ready = 1'b0;
      send(8'h20);
      expect_resp("bp", mem[0]);
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) begin
            bus.rx_output_data_valid = 1'b1;
            bus.rx_output_data       = 8'h21;
         end
         tick();
         bus.rx_output_data_valid = 1'b0;
         if (bus.tx_input_data_valid !== 1'b1 || bus.tx_input_data !== mem[0]) bad = 1'b1;
      end
      model_err();
      check8("bp_stable", {7'd0, bad}, 8'd0);
      check8("bp_drop_err", err_count, 8'(err_m));
      accept("bp");
      do_cmd("bp_idle", 8'h2F, 8'h00);

      // Byte on the acceptance cycle is dropped too
      send(8'h21);
      expect_resp("accdrop", mem[1]);
      bus.rx_output_data_valid = 1'b1;
      bus.rx_output_data       = 8'h22;
      tick();
      bus.rx_output_data_valid = 1'b0;
      model_err();
      check8("accdrop_valid_low", {7'd0, bus.tx_input_data_valid}, 8'd0);
      check8("accdrop_err", err_count, 8'(err_m));
      do_cmd("accdrop_idle", 8'h22, 8'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [7:0] c, d;
         int gap, dly;
         logic drop;
         c = 8'($urandom);
         if ($urandom_range(0, 3) != 0) c[6:4] = 3'b010;
         d    = 8'($urandom);
         gap  = $urandom_range(0, 5);
         dly  = $urandom_range(0, 3);
         drop = ($urandom_range(0, 3) == 0) && (dly > 0);
         bus.tx_output_ready = (dly == 0);
         send(c);
         if (c[6:4] == 3'b010 && c[7]) begin
            repeat (gap) tick();
            check8($sformatf("rnd%0d_wait", n), {7'd0, bus.tx_input_data_valid}, 8'd0);
            send(d);
         end
         model_cmd(c, d, r);
         expect_resp($sformatf("rnd%0d", n), r);
         bad = 1'b0;
         for (int k = 0; k < dly; k++) begin
            if (drop && k == 0) begin
               bus.rx_output_data_valid = 1'b1;
               bus.rx_output_data       = 8'($urandom);
            end
            tick();
            bus.rx_output_data_valid = 1'b0;
            if (bus.tx_input_data_valid !== 1'b1 || bus.tx_input_data !== r) bad = 1'b1;
         end
         if (drop) model_err();
         if (dly > 0) check8($sformatf("rnd%0d_hold", n), {7'd0, bad}, 8'd0);
         check8($sformatf("rnd%0d_err2", n), err_count, 8'(err_m));
         accept($sformatf("rnd%0d", n));
      end

      // Read back the whole register file
      for (int a = 0; a < 16; a++) do_cmd($sformatf("rdall%0d", a), 8'(8'h20 + a), 8'h00);

      // Error counter saturation
      bad = 1'b0;
      for (int n = 0; n < 260; n++) begin
         send(8'h00);
         model_err();
         if (bus.tx_input_data_valid !== 1'b1 || bus.tx_input_data !== NAK) bad = 1'b1;
         tick();
      end
      check8("sat_naks", {7'd0, bad}, 8'd0);
      check8("sat_err", err_count, 8'hFF);

      // Asynchronous reset in the middle of a response
      bus.tx_output_ready = 1'b0;
      send(8'h20);
      expect_resp("arst_pre", mem[0]);
      #2;
      rst_n = 1'b0;
      #1;
      check8("arst_valid", {7'd0, bus.tx_input_data_valid}, 8'd0);
      check8("arst_err", err_count, 8'h00);
      check8("arst_ctrl", ctrl_out, 8'h00);
      model_reset();
      tick();
      rst_n = 1'b1;
      bus.tx_output_ready = 1'b1;
      tick();
      for (int a = 0; a < 16; a++) do_cmd($sformatf("arst_rd%0d", a), 8'(8'h20 + a), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder for the UART link: consumes bytes delivered by the UART receiver, decodes a register read/write protocol against a 16 × 8-bit internal register file, and returns one response byte per command through the UART transmitter. Sits between the receiver output and the transmitter input inside the UART top level. It is the remote (answering) end of the link that a host drives.

## Interface
- TimeoutCycles, 20000, clk cycles allowed between a write command byte and its data byte before the write is aborted.
- AckByte, 8'h06, response byte for a completed write.
- NakByte, 8'h15, response byte for a bad header or a timed-out write.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_output_data_valid  in  1  one-cycle pulse from the receiver; the byte is on rx_output_data.
- rx_output_data  in  8  received byte, valid only with the pulse.
- tx_input_data  out  8  response byte to the transmitter.
- tx_input_data_valid  out  1  response pending; held high with stable data until accepted.
- tx_output_ready  in  1  transmitter idle and able to accept a byte.
- ctrl_out  out  8  live contents of register 0.
- err_count  out  8  saturating error counter.

## Operation
- Command byte format: bit7 = 1 write / 0 read; bits[6:4] must be 3'b010 (header check); bits[3:0] = register address.
- Register file: 16 × 8 bits, all 0x00 after reset. ctrl_out = reg[0] combinationally from the flop.
- States: IDLE, WAIT_DATA, RESP.
- IDLE, rx pulse:
  - Bad header -> resp = NakByte, err_count +1, go to RESP.
  - Read -> resp = reg[addr], go to RESP.
  - Write -> latch addr, clear timer, go to WAIT_DATA.
- IDLE, no pulse: stay.
- WAIT_DATA:
  - On an rx pulse, the byte is data with no header check: reg[addr] = byte, resp = AckByte, go to RESP.
  - Otherwise the timer increments. When it reaches TimeoutCycles-1: resp = NakByte, err_count +1, go to RESP, and no register changes.
  - An rx pulse on the timeout cycle wins: the write completes and ACK is sent.
- RESP: tx_input_data = resp, tx_input_data_valid = 1. When tx_input_data_valid && tx_output_ready in the same cycle, the byte is accepted and the block goes to IDLE.
  - An rx pulse arriving in RESP, including the acceptance cycle, is discarded with err_count +1.
- err_count saturates at 8'hFF. Simultaneous increment sources in one cycle are impossible, since only one rx pulse can occur per cycle.
- Timer width: $clog2(TimeoutCycles). It is cleared on entering WAIT_DATA.

## Timing
- Reset (async, rst_n low): state = IDLE; tx_input_data = 8'h00; tx_input_data_valid = 0; ctrl_out = 8'h00; err_count = 8'h00; timer = 0; all registers 0x00. Asserting reset mid-response drops tx_input_data_valid immediately without waiting for a clock.
- Read / bad header: tx_input_data_valid rises on the first clk edge after the rx pulse cycle (1-cycle latency).
- Write: reg[addr] and ctrl_out (if addr = 0) update on the same edge that raises tx_input_data_valid with AckByte, which is 1 cycle after the data pulse.
- Timeout: NakByte valid rises exactly TimeoutCycles cycles after the command pulse cycle.
- Handshake:
  - tx_input_data_valid falls on the edge after the acceptance cycle.
  - tx_input_data stays stable while valid is high.
  - A new command can be taken from the cycle after acceptance.
- Response throughput: at most one response outstanding; no queuing.

## Test plan
- Reset: hold rst_n low 5 cycles, then release -> ctrl_out = 0x00, err_count = 0x00, tx_input_data_valid = 0, with no response to idle line.
- Write then read reg 0: tx_output_ready = 1; rx 0xA0, then 0x5C -> response 0x06 one cycle after the data pulse, ctrl_out = 0x5C on that edge. Then rx 0x20 -> response 0x5C.
- Read unwritten register: rx 0x2F -> response 0x00, err_count unchanged.
- Bad header: rx 0x70 -> response 0x15 one cycle later, err_count = 1, no register change.
- Timeout: rx 0xA5 then idle -> 0x15 exactly TimeoutCycles cycles later, err_count +1. Follow-up rx 0x25 -> 0x00. Separately, a data pulse on cycle TimeoutCycles-1 -> 0x06 and the write takes effect.
- Backpressure/drop: tx_output_ready = 0 for 50 cycles after rx 0x20, with an extra rx 0x21 pulse during RESP -> data held stable at reg[0] with valid high, 0x21 dropped, err_count +1. After ready rises, valid falls next edge and the block returns to IDLE.
